// File: rtl/dff_char_sweep_fsm_if.sv
// Result channel of the DFF characterization sequencer: one (channel, edge) record per transfer.
// Valid holds with stable fields until ready; the transfer happens on the valid&ready cycle.
interface dff_char_sweep_fsm_if #(
  parameter int N_CH      = 4,
  parameter int DAT_DLY_W = 8
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                 res_valid;
  logic                 res_ready;
  logic [CW-1:0]        res_ch;
  logic                 res_edge;
  logic                 res_found;
  logic [DAT_DLY_W-1:0] res_code;

  modport master (
    output res_valid, res_ch, res_edge, res_found, res_code,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_ch, res_edge, res_found, res_code,
    output res_ready
  );
endinterface

// File: rtl/dff_char_sweep_fsm.sv
// Sweeps the D-path delay per enabled channel and edge, finding the first code where the captured Q is wrong.
// One result per (channel, edge); the sweep stalls in REPORT while the result port is not ready.
module dff_char_sweep_fsm #(
  parameter int N_CH       = 4,
  parameter int REF_DLY_W  = 9,
  parameter int DAT_DLY_W  = 8,
  parameter int N_REP      = 4,
  parameter int SETTLE_CYC = 4,
  parameter int Q_LAT      = 2,
  localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [N_CH-1:0]      i_ch_mask,
  input  logic [REF_DLY_W-1:0] i_ref_dly,
  input  logic [DAT_DLY_W-1:0] i_dat_min,
  input  logic [DAT_DLY_W-1:0] i_dat_max,
  input  logic                 i_q,
  output logic                 o_mode,
  output logic [REF_DLY_W-1:0] o_ref_dly_sel,
  output logic [DAT_DLY_W-1:0] o_dat_dly_sel,
  output logic [CW-1:0]        o_mux_sel,
  output logic                 o_launch,
  output logic                 o_busy,
  output logic                 o_done,
  dff_char_sweep_fsm_if.master res
);

  localparam int TMAX = (SETTLE_CYC > Q_LAT) ? SETTLE_CYC : Q_LAT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (N_REP > 1) ? $clog2(N_REP) : 1;

  typedef enum logic [3:0] {
    IDLE, NEXT_CH, PRESET, P_SETTLE, P_LAUNCH, P_WAIT,
    T_SETTLE, T_LAUNCH, T_WAIT, EVAL, REPORT, DONE
  } state_t;

  state_t               state_q, state_n;
  logic [N_CH-1:0]      mask_q, mask_n;
  logic [N_CH-1:0]      done_q, done_n;
  logic [REF_DLY_W-1:0] ref_q, ref_n;
  logic [DAT_DLY_W-1:0] min_q, min_n;
  logic [DAT_DLY_W-1:0] max_q, max_n;
  logic [CW-1:0]        ch_q, ch_n;
  logic                 edge_q, edge_n;
  logic [DAT_DLY_W-1:0] code_q, code_n;
  logic [RW-1:0]        rep_q, rep_n;
  logic [TW-1:0]        cnt_q, cnt_n;
  logic                 fail_q, fail_n;
  logic                 rfound_q, rfound_n;
  logic [DAT_DLY_W-1:0] rcode_q, rcode_n;

  logic                 have_ch;
  logic [CW-1:0]        pick_ch;

  // Lowest enabled channel not yet characterized.
  always_comb begin
    have_ch = 1'b0;
    pick_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && !done_q[i]) begin
        have_ch = 1'b1;
        pick_ch = CW'(i);
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    mask_n   = mask_q;
    done_n   = done_q;
    ref_n    = ref_q;
    min_n    = min_q;
    max_n    = max_q;
    ch_n     = ch_q;
    edge_n   = edge_q;
    code_n   = code_q;
    rep_n    = rep_q;
    cnt_n    = cnt_q;
    fail_n   = fail_q;
    rfound_n = rfound_q;
    rcode_n  = rcode_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          mask_n  = i_ch_mask;
          ref_n   = i_ref_dly;
          min_n   = i_dat_min;
          max_n   = i_dat_max;
          done_n  = '0;
          state_n = NEXT_CH;
        end
      end
      NEXT_CH: begin
        if (!have_ch) begin
          state_n = DONE;
        end else begin
          ch_n   = pick_ch;
          edge_n = 1'b0;
          code_n = min_q;
          rep_n  = '0;
          fail_n = 1'b0;
          cnt_n  = '0;
          if (min_q > max_q) begin
            // Empty range: report not-found at dat_min without launching.
            rfound_n = 1'b0;
            rcode_n  = min_q;
            state_n  = REPORT;
          end else begin
            state_n = PRESET;
          end
        end
      end
      PRESET: begin
        cnt_n   = '0;
        state_n = P_SETTLE;
      end
      P_SETTLE: begin
        if (cnt_q == TW'(SETTLE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = P_LAUNCH;
        end else begin
          cnt_n = cnt_q + TW'(1);
        end
      end
      P_LAUNCH: begin
        cnt_n   = '0;
        state_n = P_WAIT;
      end
      P_WAIT: begin
        if (cnt_q == TW'(Q_LAT - 1)) begin
          cnt_n   = '0;
          state_n = T_SETTLE;
        end else begin
          cnt_n = cnt_q + TW'(1);
        end
      end
      T_SETTLE: begin
        if (cnt_q == TW'(SETTLE_CYC - 1)) begin
          cnt_n   = '0;
          state_n = T_LAUNCH;
        end else begin
          cnt_n = cnt_q + TW'(1);
        end
      end
      T_LAUNCH: begin
        cnt_n   = '0;
        state_n = T_WAIT;
      end
      T_WAIT: begin
        if (cnt_q == TW'(Q_LAT - 1)) begin
          cnt_n = '0;
          if (i_q != ~edge_q) begin
            fail_n = 1'b1;
          end
          if (rep_q == RW'(N_REP - 1)) begin
            state_n = EVAL;
          end else begin
            rep_n   = rep_q + RW'(1);
            state_n = PRESET;
          end
        end else begin
          cnt_n = cnt_q + TW'(1);
        end
      end
      EVAL: begin
        if (fail_q) begin
          rfound_n = 1'b1;
          rcode_n  = code_q;
          state_n  = REPORT;
        end else if (code_q == max_q) begin
          // Reaching max stops the sweep, so the counter never wraps.
          rfound_n = 1'b0;
          rcode_n  = max_q;
          state_n  = REPORT;
        end else begin
          code_n  = code_q + DAT_DLY_W'(1);
          rep_n   = '0;
          fail_n  = 1'b0;
          state_n = PRESET;
        end
      end
      REPORT: begin
        if (res.res_ready) begin
          if (!edge_q) begin
            edge_n = 1'b1;
            code_n = min_q;
            rep_n  = '0;
            fail_n = 1'b0;
            if (min_q > max_q) begin
              rcode_n = min_q;
              state_n = REPORT;
            end else begin
              state_n = PRESET;
            end
          end else begin
            done_n[ch_q] = 1'b1;
            state_n      = NEXT_CH;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Abort discards the run entirely, including any pending result.
    if (state_q != IDLE && i_abort) begin
      state_n  = IDLE;
      mask_n   = '0;
      done_n   = '0;
      ref_n    = '0;
      min_n    = '0;
      max_n    = '0;
      ch_n     = '0;
      edge_n   = 1'b0;
      code_n   = '0;
      rep_n    = '0;
      cnt_n    = '0;
      fail_n   = 1'b0;
      rfound_n = 1'b0;
      rcode_n  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      done_q   <= '0;
      ref_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      ch_q     <= '0;
      edge_q   <= 1'b0;
      code_q   <= '0;
      rep_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= 1'b0;
      rfound_q <= 1'b0;
      rcode_q  <= '0;
    end else begin
      state_q  <= state_n;
      mask_q   <= mask_n;
      done_q   <= done_n;
      ref_q    <= ref_n;
      min_q    <= min_n;
      max_q    <= max_n;
      ch_q     <= ch_n;
      edge_q   <= edge_n;
      code_q   <= code_n;
      rep_q    <= rep_n;
      cnt_q    <= cnt_n;
      fail_q   <= fail_n;
      rfound_q <= rfound_n;
      rcode_q  <= rcode_n;
    end
  end

  // Preset drives D to the opposite of the target at dat_min; test drives the target at the swept code.
  always_comb begin
    o_mode        = 1'b0;
    o_dat_dly_sel = '0;
    case (state_q)
      PRESET, P_SETTLE, P_LAUNCH, P_WAIT: begin
        o_mode        = edge_q;
        o_dat_dly_sel = min_q;
      end
      T_SETTLE, T_LAUNCH, T_WAIT, EVAL: begin
        o_mode        = ~edge_q;
        o_dat_dly_sel = code_q;
      end
      default: begin
        o_mode        = 1'b0;
        o_dat_dly_sel = '0;
      end
    endcase
  end

  assign o_launch      = (state_q == P_LAUNCH) || (state_q == T_LAUNCH);
  assign o_busy        = (state_q != IDLE) && (state_q != DONE);
  assign o_done        = (state_q == DONE);
  assign o_ref_dly_sel = (state_q == IDLE) ? '0 : ref_q;
  assign o_mux_sel     = (state_q == IDLE) ? '0 : ch_q;

  assign res.res_valid = (state_q == REPORT);
  assign res.res_ch    = (state_q == REPORT) ? ch_q : '0;
  assign res.res_edge  = (state_q == REPORT) ? edge_q : 1'b0;
  assign res.res_found = (state_q == REPORT) ? rfound_q : 1'b0;
  assign res.res_code  = (state_q == REPORT) ? rcode_q : '0;

endmodule
